// File: rtl/bpsk_rx_frame_ctrl.sv
// Receive sequencer behind the BPSK demodulator: settle, bit-timing recovery,
// sync hunt (true or inverted), and payload byte assembly onto a valid/ready stream.
module bpsk_rx_frame_ctrl #(
  parameter int                    SAMPLES_PER_BIT = 16,
  parameter int                    SETTLE_CYCLES   = 64,
  parameter int                    SYNC_WIDTH      = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 16'h2DD4,
  parameter int                    PAYLOAD_BYTES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       demod_bit,
  output logic       demod_rst,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       inverted,
  output logic       overflow,
  output logic       busy
);

  localparam int PH_W = $clog2(SAMPLES_PER_BIT);
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BC_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  localparam logic [PH_W-1:0] PH_MID  = PH_W'(SAMPLES_PER_BIT / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_BIT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HUNT,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ST_W-1:0]       settle_cnt;
  logic [PH_W-1:0]       ph;
  logic [SYNC_WIDTH-1:0] sr;
  logic [2:0]            bit_cnt;
  logic [BC_W-1:0]       byte_cnt;
  logic [7:0]            byte_sr;
  logic                  prev_bit_p1;

  logic                  trans, strobe, sync_true, sync_inv;
  logic                  bit_take, byte_done, last_byte;
  logic [SYNC_WIDTH-1:0] sr_shift;
  logic [7:0]            byte_shift;

  always_comb begin
    state_nxt  = state;
    trans      = demod_bit ^ prev_bit_p1;
    strobe     = (ph == PH_MID) && !trans;
    sr_shift   = {sr[SYNC_WIDTH-2:0], demod_bit};
    sync_true  = strobe && (sr_shift == SYNC_WORD);
    sync_inv   = strobe && (sr_shift == ~SYNC_WORD);
    byte_shift = {byte_sr[6:0], demod_bit ^ inverted};
    bit_take   = (state == S_PAYLOAD) && en && strobe;
    byte_done  = bit_take && (bit_cnt == 3'd7);
    last_byte  = byte_done && (byte_cnt == BC_LAST);

    case (state)
      S_IDLE:    if (en) state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == ST_LAST) state_nxt = S_HUNT;
      S_HUNT:    if (sync_true || sync_inv) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (last_byte) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_HUNT;
      default:   state_nxt = S_IDLE;
    endcase

    if (!en) state_nxt = S_IDLE;
  end

  assign demod_rst  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  // Stage p1: control state, phase tracking and the output byte register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      ph         <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      inverted   <= 1'b0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;

      if (state == S_HUNT || state == S_PAYLOAD)
        ph <= trans ? PH_W'(1) : (ph == PH_LAST) ? '0 : ph + 1'b1;

      if (state == S_HUNT && strobe)
        sr <= sr_shift;
      // Every entry to HUNT (after settle or after a frame) starts a fresh search
      if (state_nxt == S_HUNT && state != S_HUNT)
        sr <= '0;
      if (state == S_SETTLE && state_nxt == S_HUNT) begin
        ph       <= '0;
        overflow <= 1'b0;
      end

      if (state == S_HUNT && state_nxt == S_PAYLOAD) begin
        inverted <= !sync_true;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (bit_take)
        bit_cnt <= bit_cnt + 1'b1;
      if (byte_done)
        byte_cnt <= byte_cnt + 1'b1;

      if (byte_valid && byte_ready)
        byte_valid <= 1'b0;
      // A slot freed by this cycle's accept can take the new byte immediately
      if (byte_done) begin
        if (!byte_valid || byte_ready) begin
          byte_data  <= byte_shift;
          byte_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Stage p1 datapath: previous-bit register and byte assembler
  always_ff @(posedge clk) begin
    prev_bit_p1 <= demod_bit;
    if (bit_take)
      byte_sr <= byte_shift;
  end

endmodule
